fifo_uart_tx: RTL

Single-clock UART transmitter that drains bytes from the read port of the debug-path async FIFO and serialises them as 8N1 frames on the debugger's TX pin. It sits entirely in the FIFO's read-clock domain, is the consumer end of the async FIFO, and issues pops against that FIFO's one-cycle registered read latency. It owns no storage beyond one shift register; all buffering stays in the FIFO.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/fifo_uart_tx_if.sv | 29 ++
 rtl/fifo_uart_tx_baud_gen.sv | 29 ++
 rtl/fifo_uart_tx.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: binary state encoding and line idle level.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_POP    = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_PARITY = 3'd5;
  localparam logic [2:0] ST_STOP   = 3'd6;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_POP    = ST_POP,
    S_LOAD   = ST_LOAD,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } uart_state_e;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side handshake plus serial line status, shared by the UART transmitter and its environment.
interface fifo_uart_tx_if #(parameter int WIDTH = 8);

  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             fifo_rd_en;
  logic             tx;
  logic             busy;
  logic             byte_done;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_rd_en,
    output tx,
    output busy,
    output byte_done
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_rd_en,
    input  tx,
    input  busy,
    input  byte_done
  );

endinterface

// File: rtl/fifo_uart_tx_baud_gen.sv
// Bit-time counter: tick marks the last clk cycle of each CLKS_PER_BIT-long bit; clr holds it at zero.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_r;

  // Baud counter, wrapping at the last cycle of each bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr || (cnt_r == LAST_CNT)) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign tick = (cnt_r == LAST_CNT);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining an async FIFO read port into 8N1 frames.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int WIDTH        = 8
) (
  input  logic           rd_clk,
  input  logic           rd_rst,
  fifo_uart_tx_if.master bus
);

  localparam int BW = $clog2(WIDTH) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  uart_state_e      state_r, state_nxt_s;
  logic [WIDTH-1:0] shreg_r, shreg_nxt_s;
  logic [BW-1:0]    bit_cnt_r, bit_cnt_nxt_s;
  logic             tx_r, tx_nxt_s;
  logic             rd_en_r;
  logic             busy_r;
  logic             tick_s;
  logic             baud_clr_s;
`ifdef FIFO_UART_TX_PARITY_EN
  logic             par_r, par_nxt_s;
`endif

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (rd_clk),
    .rst  (rd_rst),
    .clr  (baud_clr_s),
    .tick (tick_s)
  );

  // Next-state, next tx level and shift datapath
  always_comb begin
    state_nxt_s   = state_r;
    shreg_nxt_s   = shreg_r;
    bit_cnt_nxt_s = bit_cnt_r;
    tx_nxt_s      = tx_r;
    baud_clr_s    = 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
    par_nxt_s     = par_r;
`endif
    case (state_r)
      S_IDLE: begin
        tx_nxt_s = UART_IDLE_LEVEL;
        if (!bus.fifo_empty) begin
          state_nxt_s = S_POP;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_POP: begin
        state_nxt_s = S_LOAD;
      end
      // FIFO data is valid now, one cycle after the pop
      S_LOAD: begin
        shreg_nxt_s   = bus.fifo_rd_data;
        tx_nxt_s      = 1'b0;
        bit_cnt_nxt_s = {BW{1'b0}};
`ifdef FIFO_UART_TX_PARITY_EN
        par_nxt_s     = ^bus.fifo_rd_data;
`endif
        state_nxt_s   = S_START;
      end
      S_START: begin
        baud_clr_s = 1'b0;
        if (tick_s) begin
          tx_nxt_s    = shreg_r[0];
          shreg_nxt_s = shreg_r >> 1;
          state_nxt_s = S_DATA;
        end else begin
          state_nxt_s = S_START;
        end
      end
      S_DATA: begin
        baud_clr_s = 1'b0;
        if (tick_s) begin
          bit_cnt_nxt_s = bit_cnt_r + BW'(1);
          if (bit_cnt_r == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
            tx_nxt_s    = par_r;
            state_nxt_s = S_PARITY;
`else
            tx_nxt_s    = UART_IDLE_LEVEL;
            state_nxt_s = S_STOP;
`endif
          end else begin
            tx_nxt_s    = shreg_r[0];
            shreg_nxt_s = shreg_r >> 1;
          end
        end else begin
          state_nxt_s = S_DATA;
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        baud_clr_s = 1'b0;
        if (tick_s) begin
          tx_nxt_s    = UART_IDLE_LEVEL;
          state_nxt_s = S_STOP;
        end else begin
          state_nxt_s = S_PARITY;
        end
      end
`endif
      // Last stop cycle is the only mid-frame point where fifo_empty matters
      S_STOP: begin
        baud_clr_s = 1'b0;
        tx_nxt_s   = UART_IDLE_LEVEL;
        if (tick_s) begin
          if (!bus.fifo_empty) begin
            state_nxt_s = S_POP;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end else begin
          state_nxt_s = S_STOP;
        end
      end
      default: begin
        tx_nxt_s    = UART_IDLE_LEVEL;
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_r   <= S_IDLE;
      shreg_r   <= {WIDTH{1'b0}};
      bit_cnt_r <= {BW{1'b0}};
      tx_r      <= UART_IDLE_LEVEL;
      rd_en_r   <= 1'b0;
      busy_r    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_r     <= 1'b0;
`endif
    end else begin
      state_r   <= state_nxt_s;
      shreg_r   <= shreg_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      tx_r      <= tx_nxt_s;
      rd_en_r   <= (state_nxt_s == S_POP);
      busy_r    <= (state_nxt_s != S_IDLE);
`ifdef FIFO_UART_TX_PARITY_EN
      par_r     <= par_nxt_s;
`endif
    end
  end

  assign bus.fifo_rd_en = rd_en_r;
  assign bus.tx         = tx_r;
  assign bus.busy       = busy_r;
  assign bus.byte_done  = (state_r == S_STOP) && tick_s;

endmodule
